// File: rtl/pipelined_instr_decoder_pkg.sv
// Shared ISA constants for the decode stage: opcode values, one-hot bit indices, beat counts.
// Pure declarations; no latency or flow control of its own.
package pipelined_instr_decoder_pkg;

    localparam int NUM_OPS = 21;
    localparam int OPW     = 5;

    localparam int B_STP = 0;
    localparam int B_ADR = 1;
    localparam int B_ADM = 2;
    localparam int B_ADI = 3;
    localparam int B_SBR = 4;
    localparam int B_SBM = 5;
    localparam int B_SBI = 6;
    localparam int B_MLR = 7;
    localparam int B_MLM = 8;
    localparam int B_XSL = 9;
    localparam int B_XSR = 10;
    localparam int B_BBO = 11;
    localparam int B_BFE = 12;
    localparam int B_JMR = 13;
    localparam int B_JMP = 14;
    localparam int B_LDI = 15;
    localparam int B_STA = 16;
    localparam int B_LDR = 17;
    localparam int B_STI = 18;
    localparam int B_PSH = 19;
    localparam int B_POP = 20;

    localparam logic [OPW-1:0] OPC_STP = 5'h00;
    localparam logic [OPW-1:0] OPC_MLR = 5'h07;
    localparam logic [OPW-1:0] OPC_MLM = 5'h08;
    localparam logic [OPW-1:0] OPC_BBO = 5'h0B;
    localparam logic [OPW-1:0] OPC_JMP = 5'h0E;
    localparam logic [OPW-1:0] OPC_JMR = 5'h0F;
    localparam logic [OPW-1:0] OPC_LDR = 5'h18;
    localparam logic [OPW-1:0] OPC_STI = 5'h19;
    localparam logic [OPW-1:0] OPC_PSH = 5'h1A;
    localparam logic [OPW-1:0] OPC_POP = 5'h1B;

    function automatic int unsigned op_beats(input logic [OPW-1:0] opcode,
                                             input int unsigned    mul_steps,
                                             input int unsigned    stack_steps);
        case (opcode)
            OPC_MLR, OPC_MLM: op_beats = mul_steps;
            OPC_PSH, OPC_POP: op_beats = stack_steps;
            default:          op_beats = 1;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_instr_decoder_isa_op_decode.sv
// Combinational opcode -> one-hot op and illegal flag.
// Zero latency; no flow control.
module isa_op_decode
    import pipelined_instr_decoder_pkg::*;
(
    input  logic [OPW-1:0]     opcode_i,
    output logic [NUM_OPS-1:0] op_o,
    output logic               illegal_o
);

    always_comb begin
        op_o      = '0;
        illegal_o = 1'b0;
        if (opcode_i <= OPC_BBO) begin
            op_o[opcode_i] = 1'b1;
        end else if (opcode_i[4:1] == 4'b0110) begin
            op_o[B_BFE] = 1'b1;   // low opcode bit belongs to the operand
        end else if (opcode_i == OPC_JMP) begin
            op_o[B_JMP] = 1'b1;
        end else if (opcode_i == OPC_JMR) begin
            op_o[B_JMR] = 1'b1;
        end else if (opcode_i[4:2] == 3'b100) begin
            op_o[B_LDI] = 1'b1;
        end else if (opcode_i[4:2] == 3'b101) begin
            op_o[B_STA] = 1'b1;
        end else if (opcode_i == OPC_LDR) begin
            op_o[B_LDR] = 1'b1;
        end else if (opcode_i == OPC_STI) begin
            op_o[B_STI] = 1'b1;
        end else if (opcode_i == OPC_PSH) begin
            op_o[B_PSH] = 1'b1;
        end else if (opcode_i == OPC_POP) begin
            op_o[B_POP] = 1'b1;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/pipelined_instr_decoder.sv
// Registered decode stage emitting one or more beats per instruction, with STP halt and flush.
// Latency 1 cycle; holds outputs while dec_ready_i low, accepts a new word on the final beat's handshake.
module pipelined_instr_decoder
    import pipelined_instr_decoder_pkg::*;
#(
    parameter int IW          = 16,
    parameter int MUL_STEPS   = 4,
    parameter int STACK_STEPS = 2,
    localparam int MAXB = (MUL_STEPS > STACK_STEPS) ? ((MUL_STEPS > 2) ? MUL_STEPS : 2)
                                                    : ((STACK_STEPS > 2) ? STACK_STEPS : 2),
    localparam int CW   = $clog2(MAXB)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IW-1:0]        ir_i,
    input  logic                 ir_valid_i,
    output logic                 ir_ready_o,
    input  logic                 flush_i,
    input  logic                 resume_i,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [NUM_OPS-1:0]   op_o,
    output logic [OPW-1:0]       opcode_o,
    output logic [IW-6:0]        operand_o,
    output logic                 illegal_o,
    output logic [CW-1:0]        step_o,
    output logic                 last_o,
    output logic                 halted_o
);

    typedef enum logic [1:0] {IDLE, BEAT, HALT} state_t;

    state_t               state_q, state_d;
    logic                 dec_valid_q, dec_valid_d;
    logic [NUM_OPS-1:0]   op_q, op_d;
    logic [OPW-1:0]       opcode_q, opcode_d;
    logic [IW-6:0]        operand_q, operand_d;
    logic                 illegal_q, illegal_d;
    logic [CW-1:0]        step_q, step_d;
    logic                 last_q, last_d;
    logic                 halted_q, halted_d;
    logic [CW-1:0]        beats_m1_q, beats_m1_d;

    logic [NUM_OPS-1:0]   new_op;
    logic                 new_illegal;
    logic [CW-1:0]        new_beats_m1;
    logic [CW-1:0]        step_inc;
    logic                 accept;
    logic                 load;

    isa_op_decode u_isa_op_decode (
        .opcode_i  (ir_i[IW-1:IW-5]),
        .op_o      (new_op),
        .illegal_o (new_illegal)
    );

    assign new_beats_m1 = CW'(op_beats(ir_i[IW-1:IW-5], MUL_STEPS, STACK_STEPS) - 1);
    assign step_inc     = step_q + CW'(1);

    // Final-beat handshake frees the stage for the next word, except STP which parks in HALT.
    assign ir_ready_o = !flush_i && ((state_q == IDLE) ||
                        ((state_q == BEAT) && last_q && dec_ready_i && !op_q[B_STP]));
    assign accept     = ir_valid_i && ir_ready_o;

    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        op_d        = op_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        illegal_d   = illegal_q;
        step_d      = step_q;
        last_d      = last_q;
        halted_d    = halted_q;
        beats_m1_d  = beats_m1_q;
        load        = 1'b0;

        if (flush_i) begin
            state_d     = IDLE;
            dec_valid_d = 1'b0;
            illegal_d   = 1'b0;
            halted_d    = 1'b0;
            step_d      = '0;
            last_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: load = accept;
                BEAT: begin
                    if (dec_ready_i) begin
                        if (!last_q) begin
                            step_d = step_inc;
                            last_d = (step_inc == beats_m1_q);
                        end else if (op_q[B_STP]) begin
                            state_d     = HALT;
                            dec_valid_d = 1'b0;
                            halted_d    = 1'b1;
                        end else if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            dec_valid_d = 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (resume_i) begin
                        state_d  = IDLE;
                        halted_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            state_d     = BEAT;
            dec_valid_d = 1'b1;
            op_d        = new_op;
            opcode_d    = ir_i[IW-1:IW-5];
            operand_d   = ir_i[IW-6:0];
            illegal_d   = new_illegal;
            step_d      = '0;
            beats_m1_d  = new_beats_m1;
            last_d      = (new_beats_m1 == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dec_valid_q <= 1'b0;
            op_q        <= '0;
            opcode_q    <= '0;
            operand_q   <= '0;
            illegal_q   <= 1'b0;
            step_q      <= '0;
            last_q      <= 1'b0;
            halted_q    <= 1'b0;
            beats_m1_q  <= '0;
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            op_q        <= op_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            illegal_q   <= illegal_d;
            step_q      <= step_d;
            last_q      <= last_d;
            halted_q    <= halted_d;
            beats_m1_q  <= beats_m1_d;
        end
    end

    assign dec_valid_o = dec_valid_q;
    assign op_o        = op_q;
    assign opcode_o    = opcode_q;
    assign operand_o   = operand_q;
    assign illegal_o   = illegal_q;
    assign step_o      = step_q;
    assign last_o      = last_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Random-stimulus bench for pipelined_instr_decoder against a queue-of-pending-beats reference model.
module tb_pipelined_instr_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir_i;
    logic        ir_valid_i;
    logic        ir_ready_o;
    logic        flush_i;
    logic        resume_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [20:0] op_o;
    logic [4:0]  opcode_o;
    logic [10:0] operand_o;
    logic        illegal_o;
    logic [1:0]  step_o;
    logic        last_o;
    logic        halted_o;

    pipelined_instr_decoder #(.IW(16), .MUL_STEPS(4), .STACK_STEPS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir_i        (ir_i),
        .ir_valid_i  (ir_valid_i),
        .ir_ready_o  (ir_ready_o),
        .flush_i     (flush_i),
        .resume_i    (resume_i),
        .dec_valid_o (dec_valid_o),
        .dec_ready_i (dec_ready_i),
        .op_o        (op_o),
        .opcode_o    (opcode_o),
        .operand_o   (operand_o),
        .illegal_o   (illegal_o),
        .step_o      (step_o),
        .last_o      (last_o),
        .halted_o    (halted_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: the list of beats still to be emitted for the current instruction.
    typedef struct {
        int          idx;   // one-hot bit position, -1 for illegal
        logic [4:0]  opc;
        logic [10:0] opd;
        int          step;
        bit          last;
    } beat_t;

    beat_t m_q[$];
    bit    m_halted;

    function automatic int ref_idx(input logic [4:0] o);
        int v;
        v = int'(o);
        if (v <= 11) return v;
        if (v <= 13) return 12;
        if (v == 14) return 14;
        if (v == 15) return 13;
        if (v <= 19) return 15;
        if (v <= 23) return 16;
        if (v <= 27) return v - 7;
        return -1;
    endfunction

    function automatic int ref_beats(input int idx);
        if (idx == 7 || idx == 8)   return 4;
        if (idx == 19 || idx == 20) return 2;
        return 1;
    endfunction

    task automatic push_instr(input logic [15:0] ir);
        beat_t b;
        int    n;
        b.idx = ref_idx(ir[15:11]);
        b.opc = ir[15:11];
        b.opd = ir[10:0];
        n     = ref_beats(b.idx);
        for (int s = 0; s < n; s++) begin
            b.step = s;
            b.last = (s == n - 1);
            m_q.push_back(b);
        end
    endtask

    function automatic bit model_ready();
        if (flush_i || m_halted) return 1'b0;
        if (m_q.size() == 0) return 1'b1;
        return (m_q.size() == 1) && dec_ready_i && (m_q[0].idx != 0);
    endfunction

    task automatic check_outputs();
        logic [20:0] e_op;
        check_eq("dec_valid", {31'd0, dec_valid_o}, {31'd0, m_q.size() != 0});
        check_eq("halted",    {31'd0, halted_o},    {31'd0, m_halted});
        check_eq("ir_ready",  {31'd0, ir_ready_o},  {31'd0, model_ready()});
        if (m_q.size() != 0) begin
            e_op = '0;
            if (m_q[0].idx >= 0) e_op[m_q[0].idx] = 1'b1;
            check_eq("op",      {11'd0, op_o},      {11'd0, e_op});
            check_eq("illegal", {31'd0, illegal_o}, {31'd0, m_q[0].idx < 0});
            check_eq("opcode",  {27'd0, opcode_o},  {27'd0, m_q[0].opc});
            check_eq("operand", {21'd0, operand_o}, {21'd0, m_q[0].opd});
            check_eq("step",    {30'd0, step_o},    32'(m_q[0].step));
            check_eq("last",    {31'd0, last_o},    {31'd0, m_q[0].last});
        end
    endtask

    initial begin
        int    n_rst;
        bit    acc;
        beat_t b;

        rst_n       = 1'b0;
        ir_i        = '0;
        ir_valid_i  = 1'b0;
        flush_i     = 1'b0;
        resume_i    = 1'b0;
        dec_ready_i = 1'b0;
        m_halted    = 1'b0;
        n_rst       = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_dec_valid", {31'd0, dec_valid_o}, 32'd0);
        check_eq("rst_halted",    {31'd0, halted_o},    32'd0);
        check_eq("rst_step",      {30'd0, step_o},      32'd0);
        check_eq("rst_op",        {11'd0, op_o},        32'd0);
        check_eq("rst_ir_ready",  {31'd0, ir_ready_o},  32'd1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ir_valid_i  = ($urandom_range(0, 9) < 7);
            ir_i        = 16'($urandom);
            dec_ready_i = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 39) == 0);
            resume_i    = ($urandom_range(0, 4) == 0);
            #1;
            check_outputs();

            // Asynchronous reset in the middle of a multi-beat op must wipe it instantly.
            if (n_rst < 4 && i > 600 * (n_rst + 1) && m_q.size() >= 2) begin
                n_rst++;
                rst_n = 1'b0;
                #1;
                check_eq("arst_dec_valid", {31'd0, dec_valid_o}, 32'd0);
                check_eq("arst_step",      {30'd0, step_o},      32'd0);
                check_eq("arst_op",        {11'd0, op_o},        32'd0);
                check_eq("arst_halted",    {31'd0, halted_o},    32'd0);
                rst_n = 1'b1;
                m_q.delete();
                m_halted = 1'b0;
                #1;
                check_eq("arst_ir_ready", {31'd0, ir_ready_o}, {31'd0, model_ready()});
            end

            acc = ir_valid_i && model_ready();
            if (flush_i) begin
                m_q.delete();
                m_halted = 1'b0;
            end else begin
                if (m_halted) begin
                    if (resume_i) m_halted = 1'b0;
                end else if (m_q.size() != 0 && dec_ready_i) begin
                    b = m_q.pop_front();
                    if (b.last && b.idx == 0) m_halted = 1'b1;
                end
                if (acc) push_instr(ir_i);
            end
        end

        if (n_rst == 0)
            check_eq("mid_beat_reset_exercised", 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_instr_decoder.md
Name: pipelined_instr_decoder

Overview:
Registered, handshaked instruction-decode stage for the microprocessor datapath, placed between the instruction fetch register and the execute/control logic.
- Generalises the flat 5-bit opcode decode to a parametrised instruction width.
- Adds valid/ready flow control, multi-beat sequencing for multi-cycle ops, a halt/resume state for STP, illegal-opcode flagging and flush.

Parameters:
IW, 16, instruction width; opcode is ir_i[IW-1:IW-5], operand is ir_i[IW-6:0].
MUL_STEPS, 4, beats emitted for MLR/MLM (>=1).
STACK_STEPS, 2, beats emitted for PSH/POP (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ir_i  in  IW  instruction word
ir_valid_i  in  1  instruction offered
ir_ready_o  out  1  decoder accepts instruction
flush_i  in  1  synchronous flush
resume_i  in  1  leave HALT
dec_valid_o  out  1  decoded beat valid
dec_ready_i  in  1  downstream accepts beat
op_o  out  21  one-hot op, bit order: stp adr adm adi sbr sbm sbi mlr mlm xsl xsr bbo bfe jmr jmp ldi sta ldr sti psh pop (bit 0 = stp)
opcode_o  out  5  raw opcode
operand_o  out  IW-5  operand field
illegal_o  out  1  unmapped opcode
step_o  out  CW  beat index in multi-beat op; CW = clog2(max(MUL_STEPS,STACK_STEPS,2))
last_o  out  1  final beat of the op
halted_o  out  1  in HALT

Behaviour:
- Opcode map (5-bit):
  - 0x00-0x0B: stp..bbo, in bit order.
  - 0x0C-0x0D: bfe (low bit is an operand).
  - 0x0E: jmp.
  - 0x0F: jmr.
  - 0x10-0x13: ldi.
  - 0x14-0x17: sta.
  - 0x18: ldr; 0x19: sti; 0x1A: psh; 0x1B: pop.
  - 0x1C-0x1F: illegal (op_o = 0, illegal_o = 1).
- States: IDLE, BEAT, HALT.
- Reset (async): state = IDLE; all registered outputs are 0; ir_ready_o = 1 once state is IDLE.
- Accept: ir_valid_i & ir_ready_o. Latency is 1 cycle: on the next edge, state = BEAT, dec_valid_o = 1, fields are registered, step_o = 0.
- Beat count: MUL_STEPS for mlr/mlm, STACK_STEPS for psh/pop, 1 otherwise. last_o = (step_o == count-1).
- In BEAT, while dec_ready_i = 0, all outputs hold stable.
- On dec_ready_i = 1 and !last_o: step_o increments; other fields are unchanged.
- On dec_ready_i = 1 and last_o:
  - If the op is stp: go to HALT.
  - Else if a new instruction is accepted the same cycle: stay in BEAT with the new fields (back-to-back, zero bubble).
  - Else: go to IDLE with dec_valid_o = 0.
- ir_ready_o = !flush_i & (IDLE | (BEAT & last_o & dec_ready_i & !op_o[stp])).
- HALT: halted_o = 1, dec_valid_o = 0, ir_ready_o = 0. resume_i → IDLE on the next edge.
- Illegal opcode: one beat with illegal_o = 1; no halt. Downstream decides the trap.
- flush_i (priority over everything except reset): next state = IDLE from any state, including HALT. dec_valid_o, illegal_o, halted_o and step_o clear; any same-cycle offer is refused.
- Simultaneous resume_i and flush_i: result is IDLE (same outcome either way).
- Reset mid-beat: outputs clear immediately; no partial beat survives.

Decomposition:
- Shared package contains:
  - Opcode localparams and op bit indices.
  - NUM_OPS = 21, OPW = 5.
  - Function op_beats(opcode, MUL_STEPS, STACK_STEPS).
- One combinational sub-module, isa_op_decode: opcode → one-hot op_o plus illegal flag. The top level holds the FSM, step counter and output registers.

Test Plan:
1. ADI, ir = 0x1855, dec_ready_i = 1 → one cycle later: op_o = bit 3, opcode_o = 0x03, operand_o = 0x055, step_o = 0, last_o = 1; next cycle dec_valid_o = 0.
2. MLR, ir = 0x3800, MUL_STEPS = 4, dec_ready_i = 1 → 4 beats with step_o 0,1,2,3. last_o is high only on step 3; ir_ready_o is high only in that cycle. A second ADR offered then is emitted immediately after with no bubble.
3. ADR, ir = 0x0800, dec_ready_i low for 3 cycles → outputs held, ir_ready_o = 0. Assert flush_i on the 3rd cycle → dec_valid_o = 0 and state = IDLE next cycle.
4. STP, ir = 0x0000 → one beat, then halted_o = 1. ir_valid_i with ADI is ignored for 5 cycles. resume_i pulse → halted_o = 0 and ir_ready_o = 1 next cycle; ADI is accepted.
5. ir = 0xE000 (opcode 0x1C) → illegal_o = 1, op_o = 0, one beat, halted_o stays 0.
6. rst_n low during MLM step 2 → dec_valid_o, step_o and op_o are 0 asynchronously. After release, ir_ready_o = 1 and PSH (0xD000) yields 2 beats.
